// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//   Front-end controller for the digital clock's set/run modes. Two raw
//   push-buttons are synchronised and debounced, then drive a
//   RUN / SET_HR / SET_MIN state machine that issues single-cycle hour and
//   minute increment pulses (with auto-repeat), a count enable, and blanking
//   strobes so the display can blink the field being edited.
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset
//   btn_mode  in   raw asynchronous mode button, active-high
//   btn_inc   in   raw asynchronous increment button, active-high
//   en        out  count enable to clock counter, 1 only in RUN
//   hrup      out  one-cycle hour-increment pulse
//   minup     out  one-cycle minute-increment pulse
//   mode[1:0] out  state code: 00 RUN, 01 SET_HR, 10 SET_MIN
//   blank_hr  out  blank hour digits this cycle
//   blank_min out  blank minute digits this cycle
//
// States
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_RUN   | clock counts normally, buttons other than mode ignored
//   ST_SET_HR| hours being edited, inc adjusts hours, hour digits blink
//   ST_SET_MIN| minutes being edited, inc adjusts minutes, minute digits blink
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 20000000,
    parameter int BLINK_HALF      = 25000000,
    parameter int TIMEOUT         = 1000000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       en,
    output logic       hrup,
    output logic       minup,
    output logic [1:0] mode,
    output logic       blank_hr,
    output logic       blank_min
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_HALF + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT   = RPT_W'(REPEAT_RATE - 1);
    localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'(BLINK_HALF - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    // Bit 0 carries the mode button, bit 1 the inc button.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_prev_q, deb_prev_d;
    logic [1:0]       press_q, press_d;
    logic [DB_W-1:0]  db_cnt_m_q, db_cnt_m_d;
    logic [DB_W-1:0]  db_cnt_i_q, db_cnt_i_d;

    state_t           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             hrup_q, hrup_d;
    logic             minup_q, minup_d;
    logic             rpt_act_q, rpt_act_d;
    logic             rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             phase_q, phase_d;

    logic             in_set;
    logic             mode_ev;
    logic             inc_ev;
    logic             rpt_fire;
    logic             tmo_fire;
    logic             pulse;
    logic             state_chg;

    // Synchroniser, debounce and press-edge pipeline.
    always_comb begin
        sync1_d    = {btn_inc, btn_mode};
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        db_cnt_m_d = '0;
        db_cnt_i_d = '0;
        if (sync2_q[0] != deb_q[0]) begin
            if (db_cnt_m_q == DB_LAST) begin
                deb_d[0] = sync2_q[0];
            end else begin
                db_cnt_m_d = db_cnt_m_q + 1'b1;
            end
        end
        if (sync2_q[1] != deb_q[1]) begin
            if (db_cnt_i_q == DB_LAST) begin
                deb_d[1] = sync2_q[1];
            end else begin
                db_cnt_i_d = db_cnt_i_q + 1'b1;
            end
        end
        deb_prev_d = deb_q;
        // Registering the rising edge keeps the FSM decode off the debounce path.
        press_d    = deb_q & ~deb_prev_q;
    end

    // Mode/inc decisions, auto-repeat, timeout and blink.
    always_comb begin
        state_d     = state_q;
        in_set      = (state_q != ST_RUN);
        mode_ev     = press_q[0];
        inc_ev      = press_q[1] & in_set & ~press_q[0];
        rpt_fire    = 1'b0;
        tmo_fire    = 1'b0;
        rpt_act_d   = rpt_act_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = '0;
        tmo_cnt_d   = '0;
        blk_cnt_d   = '0;
        phase_d     = 1'b0;

        if (in_set && rpt_act_q && deb_q[1] && !mode_ev && !inc_ev) begin
            rpt_fire = (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT));
        end
        tmo_fire = in_set && (tmo_cnt_q == TMO_LAST) && !mode_ev && !inc_ev && !rpt_fire;

        if (mode_ev) begin
            case (state_q)
                ST_RUN:    state_d = ST_SET_HR;
                ST_SET_HR: state_d = ST_SET_MIN;
                default:   state_d = ST_RUN;
            endcase
        end else if (tmo_fire) begin
            state_d = ST_RUN;
        end

        pulse     = inc_ev | rpt_fire;
        state_chg = (state_d != state_q);
        hrup_d    = pulse & (state_q == ST_SET_HR);
        minup_d   = pulse & (state_q == ST_SET_MIN);
        en_d      = (state_d == ST_RUN);
        mode_d    = state_d;

        // Repeat is armed only by a real inc press inside a set state, so an
        // inc still held across a mode change never starts repeating.
        if (state_chg || state_d == ST_RUN) begin
            rpt_act_d = 1'b0;
        end else if (inc_ev) begin
            rpt_act_d   = 1'b1;
            rpt_first_d = 1'b1;
        end else if (!deb_q[1]) begin
            rpt_act_d = 1'b0;
        end
        if (rpt_fire) begin
            rpt_first_d = 1'b0;
        end
        if (rpt_act_d && !pulse) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end

        if (state_d != ST_RUN && !state_chg && !mode_ev && !pulse) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        // Restarting the blink on every adjustment shows the new value at once.
        if (state_d != ST_RUN && !state_chg && !pulse) begin
            if (blk_cnt_q == BLK_LAST) begin
                phase_d = ~phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
                phase_d   = phase_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            press_q     <= '0;
            db_cnt_m_q  <= '0;
            db_cnt_i_q  <= '0;
            state_q     <= ST_RUN;
            en_q        <= 1'b1;
            mode_q      <= 2'b00;
            hrup_q      <= 1'b0;
            minup_q     <= 1'b0;
            rpt_act_q   <= 1'b0;
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            phase_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            press_q     <= press_d;
            db_cnt_m_q  <= db_cnt_m_d;
            db_cnt_i_q  <= db_cnt_i_d;
            state_q     <= state_d;
            en_q        <= en_d;
            mode_q      <= mode_d;
            hrup_q      <= hrup_d;
            minup_q     <= minup_d;
            rpt_act_q   <= rpt_act_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign en        = en_q;
    assign mode      = mode_q;
    assign hrup      = hrup_q;
    assign minup     = minup_q;
    assign blank_hr  = (state_q == ST_SET_HR) & phase_q;
    assign blank_min = (state_q == ST_SET_MIN) & phase_q;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
- Front-end controller that sequences the digital clock's set/run modes from two raw push-buttons.
- Synchronises and debounces both buttons, then runs a RUN / SET_HR / SET_MIN state machine.
- Drives the clock counter's en, hrup and minup inputs as single-cycle pulses.
- Provides blanking strobes so the display can blink the field being edited.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive cycles a synchronised button must differ from its debounced value before the change is accepted (10 ms @ 100 MHz)
REPEAT_DELAY, 50000000, cycles inc must be held after the press before the first auto-repeat pulse
REPEAT_RATE, 20000000, cycles between subsequent auto-repeat pulses
BLINK_HALF, 25000000, cycles per blink half-period
TIMEOUT, 1000000000, cycles without a press event in a set state before returning to RUN

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
btn_mode  in  1  raw asynchronous mode button, active-high
btn_inc  in  1  raw asynchronous increment button, active-high
en  out  1  count enable to clock counter, 1 only in RUN
hrup  out  1  one-cycle hour-increment pulse
minup  out  1  one-cycle minute-increment pulse
mode  out  2  state code: 00 RUN, 01 SET_HR, 10 SET_MIN
blank_hr  out  1  blank hour digits this cycle
blank_min  out  1  blank minute digits this cycle

Behaviour:
- Reset values (rst high at a posedge): state RUN, en=1, mode=00, hrup=minup=blank_hr=blank_min=0. All counters = 0, synchronisers and debounced values = 0. Reset mid-operation aborts any set state, pending repeat or debounce.
- Synchronisers: 2-flop per button.
- Debounce: counter per button.
  - Counter clears whenever the sync value equals the debounced value.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, the debounced value takes the sync value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
- Press event: debounced rising edge, one cycle wide. Release produces no event.
- Latency: raw rise held stable at edge 0 → hrup/minup high for exactly one cycle at edge DEBOUNCE_CYCLES+3.
- FSM transitions on mode press: RUN→SET_HR→SET_MIN→RUN.
- mode output and en are registered from the next state, so they update in the same cycle as the transition.
- inc press:
  - SET_HR → hrup pulse.
  - SET_MIN → minup pulse.
  - RUN → ignored; no pulse, no repeat.
- Simultaneous mode and inc press in the same cycle: mode wins, no increment pulse, repeat counter cleared.
- Auto-repeat, only in SET_HR/SET_MIN while debounced inc=1:
  - Repeat counter clears on press event.
  - First extra pulse fires REPEAT_DELAY cycles after the press pulse; further pulses every REPEAT_RATE cycles.
  - Stops on release or on state change.
  - Repeat pulses count as press events for timeout.
- hrup and minup are never high together and never high in RUN.
- Timeout counter:
  - Runs only in set states.
  - Clears on entry and on any mode or inc event.
  - On reaching TIMEOUT-1 with no event, state returns to RUN; no increment is issued.
  - Timeout and a mode press in the same cycle: the mode press is taken.
- Blink:
  - Phase bit toggles every BLINK_HALF cycles while in a set state.
  - Phase and blink counter clear on every state change and on every hrup/minup pulse, so the edited digits are visible immediately after an adjustment.
  - blank_hr = (state==SET_HR) & phase; blank_min = (state==SET_MIN) & phase. Both are 0 in RUN.
- Counter widths: sized to hold their largest parameter (TIMEOUT needs 30 bits at default). No wrap is reachable.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, BLINK_HALF=5, TIMEOUT=100.
1. Reset → en=1, mode=00, all pulses/blanks 0. btn_inc pressed 10 cycles in RUN → no hrup/minup, en stays 1.
2. btn_mode raw high from edge 0 → mode=01, en=0 at edge 7. Second press → 10; third → 00, en=1.
3. In SET_HR, btn_inc high at edge 0 for 10 cycles → hrup high only at edge 7. A 3-cycle btn_inc glitch → no pulse.
4. In SET_MIN, hold btn_inc 50 cycles → minup at edges 7, 27, 35, 43, 51 only. Release → no further pulses.
5. Enter SET_HR, no input → blank_hr toggles every 5 cycles, blank_min=0. After 100 cycles mode=00, en=1, blank_hr=0.
6. btn_mode and btn_inc rise on the same cycle in SET_HR → mode=10, no hrup/minup. Assert rst mid-hold in SET_MIN → state RUN next edge, no repeat pulses afterwards.
